mips_cpu_harvard_core: RTL and testbench
========================================

Name: mips_cpu_harvard_core

Overview:
Single-cycle 32-bit MIPS-I subset CPU with separate instruction and data buses (Harvard).
- Fetches from a combinational-read instruction memory.
- Performs loads and stores through a combinational-read, single-cycle-write data memory.
- Runs from reset vector 0xBFC00000 until it jumps to address 0, then halts.
- Sits at the top of the CPU hierarchy. Bench-side ROM/RAM models attach directly to its buses.

Parameters:
None. The reset vector 0xBFC00000 and the halt address 0x00000000 are fixed constants in the package.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
active  output  1  high while executing; low once the CPU has halted
register_v0  output  32  live value of register $2, combinational from the register file
clk_enable  input  1  when low, no architectural state changes on the clock edge
instr_address  output  32  byte address of the current instruction (the PC)
instr_readdata  input  32  instruction word at instr_address, combinational
data_address  output  32  byte address for load/store = rs + sign-extended imm16
data_write  output  1  high for one cycle during SW; memory writes at the rising edge
data_read  output  1  high during LW
data_writedata  output  32  rt value during SW
data_readdata  input  32  load data, combinational, valid in the same cycle as data_read

Behaviour:
- Reset (clk edge with reset=1, regardless of clk_enable):
  - PC=0xBFC00000, all 32 GPRs=0, active=1, delay-slot state cleared.
  - During reset, data_write=0 and data_read=0.
- Execution model:
  - Each rising edge with clk_enable=1, reset=0 and active=1 retires the instruction at PC.
  - Otherwise PC, GPRs and active hold.
- Supported instructions:
  - ADDU (op 0, funct 0x21): rd = rs + rt, mod 2^32, no overflow trap.
  - ADDIU (op 0x09): rt = rs + sext(imm16), mod 2^32.
  - LW (op 0x23): rt = data_readdata, with data_read=1 and data_address = rs + sext(imm16).
  - SW (op 0x2B): data_write=1, data_writedata = rt, same address formula as LW.
  - JR (op 0, funct 0x08): jump to rs after one branch-delay slot. The delay-slot instruction at PC+4 always executes.
- Any other encoding executes as a NOP: PC += 4, no register write, no memory strobe.
- $0 always reads 0. Writes to $0 are discarded.
- Next PC:
  - Normally PC+4.
  - In the cycle after JR retires, next PC is the latched jump target.
  - JR inside a delay slot: unsupported, behaviour undefined.
- Halt: when the PC update loads 0x00000000, active goes low on that same edge. Thereafter:
  - No register writes.
  - data_write=0 and data_read=0.
  - PC stays 0.
- Strobe gating:
  - data_read and data_write are combinational from the decoded instruction.
  - Both are forced low when active=0 or clk_enable=0.
- Addresses are not checked for alignment. The full 32-bit address is driven and the memory ignores bits [1:0].
- Same-cycle register read and write of one register: the read returns the old value; the new value is visible next cycle.

Decomposition:
- Package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_ADDIU, OP_LW, OP_SW;
  - funct constants: FN_ADDU, FN_JR;
  - RESET_VECTOR=32'hBFC00000 and HALT_ADDR=32'h0;
  - instruction-field typedef struct: op, rs, rt, rd, shamt, funct, imm16.
- One sub-module, mips_regfile:
  - 32x32 registers;
  - two combinational read ports;
  - one synchronous write port;
  - synchronous reset clears all registers;
  - dedicated v0 output.

Test Plan:
- Reset then release → instr_address=0xBFC00000, active=1, register_v0=0, data_write=0, data_read=0.
- Program ADDIU $2,$0,0x45; JR $0; ADDIU $2,$2,1 (delay slot) → register_v0=0x46; active falls on the edge that loads PC=0; PC holds 0.
- ADDIU $2,$0,0xFFFF → register_v0=0xFFFFFFFF. Then ADDU $2,$2,$2 → 0xFFFFFFFE (wrap, no trap).
- Store/load sequence:
  - ADDIU $3,$0,0x10; ADDIU $4,$0,0x1234.
  - SW $4,0($3) → data_write=1, data_address=0x10, data_writedata=0x1234 for exactly one cycle.
  - LW $2,0($3) → data_read=1, register_v0=0x1234.
- ADDIU $0,$0,5 then ADDU $2,$0,$0 → register_v0=0 ($0 stays zero).
- Hold clk_enable=0 for 3 edges mid-program → instr_address and register_v0 unchanged, no memory strobes; execution resumes where it stopped when clk_enable returns high.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, fixed addresses and the instruction field
// bundle for the single-cycle MIPS core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
  } instr_t;

  function automatic instr_t decode(input logic [31:0] w);
    instr_t f;
    f.op    = w[31:26];
    f.rs    = w[25:21];
    f.rt    = w[20:16];
    f.rd    = w[15:11];
    f.shamt = w[10:6];
    f.funct = w[5:0];
    f.imm16 = w[15:0];
    return f;
  endfunction

endpackage

// File: rtl/mips_cpu_harvard_core_regfile.sv
// 32x32 GPR file: two async read ports, one sync write port, $0 hardwired
// to zero, plus a live view of $2.
module mips_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic [31:0] v0
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];
  assign v0      = regs[2];

endmodule

// File: rtl/mips_cpu_harvard_core.sv
// Single-cycle MIPS-I subset core (ADDU/ADDIU/LW/SW/JR) on Harvard buses;
// halts once the PC is loaded with address 0.
module mips_cpu_harvard_core
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  logic [31:0] pc;
  logic [31:0] jump_target;
  logic        delay_pending;

  instr_t      ins;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] sext_imm;
  logic [31:0] next_pc;
  logic        is_addu, is_addiu, is_lw, is_sw, is_jr;
  logic        retire;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign ins      = decode(instr_readdata);
  assign sext_imm = {{16{ins.imm16[15]}}, ins.imm16};

  // R-type ops only count with shamt=0; anything else falls through as NOP
  assign is_addu  = ins.op == OP_RTYPE && ins.funct == FN_ADDU
                    && ins.shamt == 5'd0;
  assign is_jr    = ins.op == OP_RTYPE && ins.funct == FN_JR
                    && ins.shamt == 5'd0;
  assign is_addiu = ins.op == OP_ADDIU;
  assign is_lw    = ins.op == OP_LW;
  assign is_sw    = ins.op == OP_SW;

  assign retire = clk_enable && active && !reset;

  mips_regfile u_rf (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (ins.rs),
    .raddr_b (ins.rt),
    .rdata_a (rs_val),
    .rdata_b (rt_val),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .v0      (register_v0)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ins.rt;
    rf_wdata = rs_val + sext_imm;
    unique case (1'b1)
      is_addu: begin
        rf_we    = retire;
        rf_waddr = ins.rd;
        rf_wdata = rs_val + rt_val;
      end
      is_addiu: rf_we = retire;
      is_lw: begin
        rf_we    = retire;
        rf_wdata = data_readdata;
      end
      default: ;
    endcase
  end

  assign instr_address  = pc;
  assign data_address   = rs_val + sext_imm;
  assign data_writedata = rt_val;
  assign data_read      = is_lw && retire;
  assign data_write     = is_sw && retire;

  assign next_pc = delay_pending ? jump_target : pc + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_VECTOR;
      active        <= 1'b1;
      delay_pending <= 1'b0;
      jump_target   <= '0;
    end else if (retire) begin
      pc            <= next_pc;
      active        <= (next_pc != HALT_ADDR);
      delay_pending <= is_jr;
      jump_target   <= rs_val;
    end
  end

endmodule

// File: tb/tb_mips_cpu_harvard_core.sv
// Directed program bench: an ISA-level model steps alongside the core and
// is compared every cycle; literal checkpoints pin the model itself.
module tb_mips_cpu_harvard_core;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        active;
  logic [31:0] register_v0;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  int passed = 0;
  int total  = 0;

  mips_cpu_harvard_core dut (
    .clk            (clk),
    .reset          (reset),
    .active         (active),
    .register_v0    (register_v0),
    .clk_enable     (clk_enable),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [5:0] op,
    input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs,
    input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  logic [31:0] prog [14];

  initial begin
    prog[0]  = enc_i(6'h09, 5'd0, 5'd2, 16'h0045);
    prog[1]  = enc_i(6'h09, 5'd2, 5'd2, 16'h0001);
    prog[2]  = enc_i(6'h09, 5'd0, 5'd2, 16'hFFFF);
    prog[3]  = enc_r(5'd2, 5'd2, 5'd2, 6'h21);
    prog[4]  = enc_i(6'h09, 5'd0, 5'd3, 16'h0010);
    prog[5]  = enc_i(6'h09, 5'd0, 5'd4, 16'h1234);
    prog[6]  = enc_i(6'h2B, 5'd3, 5'd4, 16'h0000);
    prog[7]  = enc_i(6'h23, 5'd3, 5'd2, 16'h0000);
    prog[8]  = enc_i(6'h09, 5'd0, 5'd0, 16'h0005);
    prog[9]  = enc_r(5'd0, 5'd0, 5'd2, 6'h21);
    prog[10] = 32'h3C02_1234;
    prog[11] = enc_i(6'h09, 5'd0, 5'd2, 16'h0045);
    prog[12] = enc_r(5'd0, 5'd0, 5'd0, 6'h08);
    prog[13] = enc_i(6'h09, 5'd2, 5'd2, 16'h0001);
  end

  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [31:0] off;
    off = a - RV;
    if (a >= RV && off[31:2] < 14) return prog[off[31:2]];
    return 32'h0;
  endfunction

  assign instr_readdata = rom(instr_address);

  logic [31:0] ram [64];
  initial for (int i = 0; i < 64; i++) ram[i] = '0;
  assign data_readdata = ram[data_address[7:2]];
  always @(posedge clk)
    if (data_write) ram[data_address[7:2]] <= data_writedata;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // ISA-level reference: architectural state advanced one instruction per
  // enabled edge, driven only by bench-owned inputs.
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [64];
  logic [31:0] m_pc;
  logic        m_active;
  logic        m_valid = 1'b0;
  bit          m_slot;
  logic [31:0] m_target;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = RV;
      m_active = 1'b1;
      m_slot = 1'b0;
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      for (int i = 0; i < 64; i++) m_mem[i] = '0;
      m_valid = 1'b1;
    end else if (m_valid && clk_enable && m_active) begin
      logic [31:0] w, a, b, ea, npc;
      bit          jr;
      w  = rom(m_pc);
      a  = m_reg[w[25:21]];
      b  = m_reg[w[20:16]];
      ea = a + {{16{w[15]}}, w[15:0]};
      jr = 1'b0;
      npc = m_slot ? m_target : m_pc + 4;
      if (w[31:26] == 6'h00 && w[10:6] == 0 && w[5:0] == 6'h21)
        m_reg[w[15:11]] = a + b;
      else if (w[31:26] == 6'h00 && w[10:6] == 0 && w[5:0] == 6'h08)
        jr = 1'b1;
      else if (w[31:26] == 6'h09)
        m_reg[w[20:16]] = ea;
      else if (w[31:26] == 6'h23)
        m_reg[w[20:16]] = m_mem[ea[7:2]];
      else if (w[31:26] == 6'h2B)
        m_mem[ea[7:2]] = b;
      m_reg[0] = '0;
      m_slot = jr;
      m_target = a;
      m_pc = npc;
      if (npc == 0) m_active = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (m_valid) begin
      logic [31:0] w;
      bit en, exp_rd, exp_wr;
      w  = rom(m_pc);
      en = !reset && clk_enable && m_active;
      exp_rd = en && w[31:26] == 6'h23;
      exp_wr = en && w[31:26] == 6'h2B;
      chk("pc", instr_address, m_pc);
      chk("active", {31'd0, active}, {31'd0, m_active});
      chk("v0", register_v0, m_reg[2]);
      chk("data_read", {31'd0, data_read}, {31'd0, exp_rd});
      chk("data_write", {31'd0, data_write}, {31'd0, exp_wr});
      if (exp_rd || exp_wr)
        chk("data_address", data_address,
            m_reg[w[25:21]] + {{16{w[15]}}, w[15:0]});
      if (exp_wr)
        chk("data_writedata", data_writedata, m_reg[w[20:16]]);
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #3;
  endtask

  initial begin
    reset = 1'b1;
    clk_enable = 1'b1;
    run(2);
    chk("rst_write", {31'd0, data_write}, 32'd0);
    chk("rst_read", {31'd0, data_read}, 32'd0);
    reset = 1'b0;
    #1;
    chk("lit_pc0", instr_address, 32'hBFC0_0000);
    chk("lit_active0", {31'd0, active}, 32'd1);
    chk("lit_v0_0", register_v0, 32'd0);
    run(1);
    chk("lit_v0_45", register_v0, 32'h45);
    run(1);
    chk("lit_v0_46", register_v0, 32'h46);
    run(1);
    chk("lit_v0_ffff", register_v0, 32'hFFFF_FFFF);
    run(1);
    chk("lit_v0_wrap", register_v0, 32'hFFFF_FFFE);
    run(2);
    chk("lit_sw_we", {31'd0, data_write}, 32'd1);
    chk("lit_sw_addr", data_address, 32'h10);
    chk("lit_sw_data", data_writedata, 32'h1234);
    clk_enable = 1'b0;
    #1;
    chk("lit_stall_we", {31'd0, data_write}, 32'd0);
    run(3);
    chk("lit_stall_pc", instr_address, 32'hBFC0_0018);
    chk("lit_stall_v0", register_v0, 32'hFFFF_FFFE);
    chk("lit_stall_ram", ram[4], 32'd0);
    clk_enable = 1'b1;
    run(1);
    chk("lit_lw_rd", {31'd0, data_read}, 32'd1);
    chk("lit_lw_we", {31'd0, data_write}, 32'd0);
    chk("lit_ram", ram[4], 32'h1234);
    run(1);
    chk("lit_v0_lw", register_v0, 32'h1234);
    run(2);
    chk("lit_v0_zero", register_v0, 32'd0);
    run(1);
    chk("lit_nop_pc", instr_address, 32'hBFC0_002C);
    chk("lit_nop_v0", register_v0, 32'd0);
    run(2);
    chk("lit_jr_active", {31'd0, active}, 32'd1);
    chk("lit_jr_pc", instr_address, 32'hBFC0_0034);
    run(1);
    chk("lit_halt_v0", register_v0, 32'h46);
    chk("lit_halt_pc", instr_address, 32'd0);
    chk("lit_halt_active", {31'd0, active}, 32'd0);
    run(3);
    chk("lit_hold_pc", instr_address, 32'd0);
    chk("lit_hold_v0", register_v0, 32'h46);
    chk("lit_hold_rd", {31'd0, data_read}, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
